tmp101_read_sequencer: RTL

Transaction-level controller that sits above the I2C byte engine (baud generator + bit controller + shift datapath) and sequences a complete TMP101 temperature read. On a Go request it runs two I2C transactions: it sets the pointer register to 0x00, then reads the two temperature bytes. It returns a 12-bit result with a one-cycle valid strobe. It flags slave NACKs and engine timeouts, and aborts the bus when either occurs.

---
 rtl/tmp101_read_sequencer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/tmp101_read_sequencer.sv
// TMP101 temperature read sequencer: writes the pointer register, then reads the two
// temperature bytes through a byte-level I2C engine, aborting the bus on NACK or timeout.
module tmp101_read_sequencer #(
    parameter logic [6:0]  SlaveAddress  = 7'b1001000,
    parameter logic [7:0]  PointerValue  = 8'h00,
    parameter int unsigned TimeoutCycles = 40000
) (
    input  logic        clock,
    input  logic        Reset,
    input  logic        Go,
    output logic        ByteStart,
    output logic [3:0]  ByteCmd,
    output logic [7:0]  TxByte,
    input  logic        ByteDone,
    input  logic        AckReceived,
    input  logic [7:0]  RxByte,
    output logic        BusAbort,
    output logic [11:0] Temperature,
    output logic        Valid,
    output logic        Busy,
    output logic        Error
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PTR_ADDR = 3'd1,
        PTR_DATA = 3'd2,
        RD_ADDR  = 3'd3,
        RD_MSB   = 3'd4,
        RD_LSB   = 3'd5,
        DONE     = 3'd6,
        ERROR    = 3'd7
    } state_t;

    // The counter is 0 in the ByteStart cycle; ERROR is entered on the edge where it
    // would reach TimeoutCycles-1.
    localparam logic [19:0] TimeoutLast = 20'(TimeoutCycles - 2);

    state_t      state_q, state_d;
    logic        byteStart_q, byteStart_d;
    logic [3:0]  byteCmd_q, byteCmd_d;
    logic [7:0]  txByte_q, txByte_d;
    logic        busAbort_q, busAbort_d;
    logic [11:0] temperature_q, temperature_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic        error_q, error_d;
    logic [19:0] timeout_q, timeout_d;
    logic [7:0]  msbHold_q, msbHold_d;

    logic waiting;
    logic acceptDone;
    logic timedOut;
    logic unusedRxLow;

    function automatic logic isByteState(input state_t s);
        return (s == PTR_ADDR) || (s == PTR_DATA) || (s == RD_ADDR) ||
               (s == RD_MSB) || (s == RD_LSB);
    endfunction

    function automatic logic [3:0] cmdFor(input state_t s);
        case (s)
            PTR_ADDR: return 4'b1000;
            PTR_DATA: return 4'b0100;
            RD_ADDR:  return 4'b1000;
            RD_MSB:   return 4'b0011;
            RD_LSB:   return 4'b0110;
            default:  return 4'b0000;
        endcase
    endfunction

    function automatic logic [7:0] txFor(input state_t s);
        case (s)
            PTR_ADDR: return {SlaveAddress, 1'b0};
            PTR_DATA: return PointerValue;
            RD_ADDR:  return {SlaveAddress, 1'b1};
            default:  return 8'h00;
        endcase
    endfunction

    // ByteDone is only honoured after the ByteStart cycle of a byte state.
    assign waiting     = isByteState(state_q) && !byteStart_q;
    assign acceptDone  = waiting && ByteDone;
    assign timedOut    = waiting && (timeout_q == TimeoutLast);
    assign unusedRxLow = ^RxByte[3:0];

    always_comb begin
        state_d       = state_q;
        byteStart_d   = 1'b0;
        byteCmd_d     = byteCmd_q;
        txByte_d      = txByte_q;
        busAbort_d    = 1'b0;
        temperature_d = temperature_q;
        valid_d       = 1'b0;
        error_d       = error_q;
        msbHold_d     = msbHold_q;
        timeout_d     = isByteState(state_q) ? timeout_q + 20'd1 : 20'd0;

        case (state_q)
            IDLE: begin
                if (Go) begin
                    state_d = PTR_ADDR;
                    error_d = 1'b0;
                end
            end
            PTR_ADDR: begin
                if (acceptDone)    state_d = AckReceived ? PTR_DATA : ERROR;
                else if (timedOut) state_d = ERROR;
            end
            PTR_DATA: begin
                if (acceptDone)    state_d = AckReceived ? RD_ADDR : ERROR;
                else if (timedOut) state_d = ERROR;
            end
            RD_ADDR: begin
                if (acceptDone)    state_d = AckReceived ? RD_MSB : ERROR;
                else if (timedOut) state_d = ERROR;
            end
            RD_MSB: begin
                if (acceptDone) begin
                    msbHold_d = RxByte;
                    state_d   = RD_LSB;
                end else if (timedOut) begin
                    state_d = ERROR;
                end
            end
            RD_LSB: begin
                if (acceptDone) begin
                    temperature_d = {msbHold_q, RxByte[7:4]};
                    valid_d       = 1'b1;
                    state_d       = DONE;
                end else if (timedOut) begin
                    state_d = ERROR;
                end
            end
            DONE:    state_d = IDLE;
            ERROR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            byteStart_d = isByteState(state_d);
            byteCmd_d   = cmdFor(state_d);
            txByte_d    = txFor(state_d);
            timeout_d   = 20'd0;
        end

        if (state_d == ERROR) begin
            busAbort_d = 1'b1;
            error_d    = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (Reset) begin
            state_q       <= IDLE;
            byteStart_q   <= 1'b0;
            byteCmd_q     <= 4'b0000;
            txByte_q      <= 8'h00;
            busAbort_q    <= 1'b0;
            temperature_q <= 12'h000;
            valid_q       <= 1'b0;
            busy_q        <= 1'b0;
            error_q       <= 1'b0;
            timeout_q     <= 20'd0;
            msbHold_q     <= 8'h00;
        end else begin
            state_q       <= state_d;
            byteStart_q   <= byteStart_d;
            byteCmd_q     <= byteCmd_d;
            txByte_q      <= txByte_d;
            busAbort_q    <= busAbort_d;
            temperature_q <= temperature_d;
            valid_q       <= valid_d;
            busy_q        <= busy_d;
            error_q       <= error_d;
            timeout_q     <= timeout_d;
            msbHold_q     <= msbHold_d;
        end
    end

    assign ByteStart   = byteStart_q;
    assign ByteCmd     = byteCmd_q;
    assign TxByte      = txByte_q;
    assign BusAbort    = busAbort_q;
    assign Temperature = temperature_q;
    assign Valid       = valid_q;
    assign Busy        = busy_q;
    assign Error       = error_q;

endmodule
